// File: rtl/spi_pkg.sv
// Package spi_pkg
// Purpose: constants and types shared by the SPI slave receiver and the lab
//   SPI master: mode bits, the default frame width, the minimum synchronizer
//   depth and the receiver FSM state encoding.
// Ports: none (package).
package spi_pkg;

  // Mode 0: sclk idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  // Frame width shared with the lab master.
  localparam int SPI_DATA_W = 8;

  // Two flops are the least that gives metastability protection.
  localparam int SPI_SYNC_FF_MIN = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Module spi_sync_edge
// Purpose: brings one asynchronous pin into the clk domain through a
//   SYNC_FF-deep flop chain and produces single-cycle rise/fall pulses by
//   comparing the synchronized level against its previous sample.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   din    in   asynchronous pin
//   sync   out  synchronized level
//   rise   out  1-clk pulse on a 0->1 transition of sync
//   fall   out  1-clk pulse on a 1->0 transition of sync
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   SYNC_FF = SPI_SYNC_FF_MIN,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_FF-1:0] chain;
  logic               prev;

  // The previous-sample flop resets to the same value as the chain so that
  // leaving reset never fakes an edge (important for ss, which idles high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {SYNC_FF{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[SYNC_FF-2:0], din};
      prev  <= chain[SYNC_FF-1];
    end
  end

  assign sync = chain[SYNC_FF-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave_mode0_rx.sv
// Module spi_slave_mode0_rx
// Purpose: SPI mode-0 (CPOL=0, CPHA=0) slave that oversamples sclk/ss/mosi in
//   the clk domain, assembles MSB-first DATA_W-bit words and offers each word
//   on a valid/ready handshake. Requires clk >= 4x sclk.
// Configuration macro: SPI_SLAVE_MISO_EN adds the tx_data/miso ports and a
//   transmit shifter for full-duplex operation; without it the block is
//   receive-only.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   sclk       in   SPI clock from master (async)
//   ss         in   slave select, active-low (async)
//   mosi       in   serial data from master (async)
//   rx_data    out  last complete word, stable while rx_valid=1
//   rx_valid   out  word available, clears after rx_valid&&rx_ready
//   rx_ready   in   consumer accepts rx_data
//   overrun    out  1-clk pulse: word completed while previous still pending
//   frame_err  out  1-clk pulse: ss rose mid-word
//   busy       out  1 while a frame is in progress
//   tx_data    in   (SPI_SLAVE_MISO_EN) word to transmit
//   miso       out  (SPI_SLAVE_MISO_EN) serial data to master
module spi_slave_mode0_rx
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int SYNC_FF = SPI_SYNC_FF_MIN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              frame_err,
`ifdef SPI_SLAVE_MISO_EN
  input  logic [DATA_W-1:0] tx_data,
  output logic              miso,
`endif
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  logic sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s;

  spi_state_t        state;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift;
`ifdef SPI_SLAVE_MISO_EN
  logic [DATA_W-1:0] tx_shift;
`endif

  spi_sync_edge #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_sync_sclk (
    .clk (clk), .rst_n(rst_n), .din(sclk),
    .sync(), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b1)) u_sync_ss (
    .clk (clk), .rst_n(rst_n), .din(ss),
    .sync(ss_s), .rise(ss_rise), .fall(ss_fall)
  );

  // mosi passes through the same depth as sclk, so mosi_s is aligned with
  // the sclk_rise pulse that samples it.
  spi_sync_edge #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk), .rst_n(rst_n), .din(mosi),
    .sync(mosi_s), .rise(), .fall()
  );

  // Receiver FSM. A word whose last bit arrived is held in bit_cnt==DATA_W for
  // one clk and delivered from there; that state also catches an ss_rise that
  // coincided with the final sclk_rise, so such a word completes without
  // frame_err. clk >= 4x sclk guarantees no sclk edge lands in that clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef SPI_SLAVE_MISO_EN
      tx_shift  <= '0;
`endif
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          busy    <= 1'b0;
          bit_cnt <= '0;
          if (ss_fall) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            shift   <= '0;
`ifdef SPI_SLAVE_MISO_EN
            tx_shift <= tx_data;
`endif
          end
        end

        SHIFT: begin
          if (bit_cnt == CNT_FULL) begin
            // Completion overrides the handshake clear above, so a same-clk
            // accept simply loads the new word with no overrun.
            rx_data  <= shift;
            rx_valid <= 1'b1;
            if (rx_valid && !rx_ready) begin
              overrun <= 1'b1;
            end
            bit_cnt <= '0;
`ifdef SPI_SLAVE_MISO_EN
            tx_shift <= tx_data;
`endif
            if (ss_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            if (sclk_rise) begin
              shift   <= {shift[DATA_W-2:0], mosi_s};
              bit_cnt <= bit_cnt + 1'b1;
            end
`ifdef SPI_SLAVE_MISO_EN
            // The falling edge after the last bit of a word arrives with
            // bit_cnt already 0 and must not consume the freshly loaded MSB.
            if (sclk_fall && bit_cnt != '0) begin
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
`endif
            if (ss_rise && !(sclk_rise && bit_cnt == CNT_LAST)) begin
              state   <= IDLE;
              busy    <= 1'b0;
              bit_cnt <= '0;
              if (bit_cnt != '0) begin
                frame_err <= 1'b1;
              end
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_SLAVE_MISO_EN
  assign miso = busy & ~ss_s & tx_shift[DATA_W-1];
`else
  logic unused_sclk_fall;
  assign unused_sclk_fall = sclk_fall;
`endif

endmodule
